// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle MULT/MULTU/DIV/DIVU sequencer:
// operation encodings, FSM states and the default operand width.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Combinational step logic: one shift-add multiply step, one restoring
// divide step, and the sign fix-up applied to the finished magnitudes.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic [WIDTH-1:0] acc_i,   // accumulator / partial remainder
    input  logic [WIDTH-1:0] lo_i,    // multiplier / dividend-quotient
    input  logic [WIDTH-1:0] opnd_i,  // multiplicand / divisor magnitude
    input  logic             is_div_i,
    input  logic             div_zero_i,
    input  logic             sign_a_i,
    input  logic             sign_b_i,
    output logic [WIDTH-1:0] mul_acc_o,
    output logic [WIDTH-1:0] mul_lo_o,
    output logic [WIDTH-1:0] div_acc_o,
    output logic [WIDTH-1:0] div_lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         rem_sh;
    logic [WIDTH-1:0]       rem_diff;
    logic [2*WIDTH-1:0]     prod;
    logic [2*WIDTH-1:0]     prod_s;

    always_comb begin
        // Add the multiplicand when the multiplier LSB is set, then shift the
        // {carry, acc, multiplier} chain right by one.
        sum       = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        mul_acc_o = sum[WIDTH:1];
        mul_lo_o  = {sum[0], lo_i[WIDTH-1:1]};
    end

    always_comb begin
        rem_sh   = {acc_i, lo_i[WIDTH-1]};
        rem_diff = rem_sh[WIDTH-1:0] - opnd_i;
        if (rem_sh >= {1'b0, opnd_i}) begin
            div_acc_o = rem_diff;
            div_lo_o  = {lo_i[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_o = rem_sh[WIDTH-1:0];
            div_lo_o  = {lo_i[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod   = {acc_i, lo_i};
        prod_s = (sign_a_i ^ sign_b_i) ? -prod : prod;
        if (is_div_i && div_zero_i) begin
            // acc holds the raw dividend for a divide-by-zero
            hi_o = acc_i;
            lo_o = '1;
        end else if (is_div_i) begin
            hi_o = sign_a_i ? -acc_i : acc_i;
            lo_o = (sign_a_i ^ sign_b_i) ? -lo_i : lo_i;
        end else begin
            hi_o = prod_s[2*WIDTH-1:WIDTH];
            lo_o = prod_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside Execute: runs the iterative
// datapath, produces the HI/LO write pulse and stalls only HI/LO consumers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             ReadHILO,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             WriteHI,
    output logic             WriteLO,
    output logic [WIDTH-1:0] HIOut,
    output logic [WIDTH-1:0] LOOut,
    output logic             DivByZero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, lo_q, opnd_q, hi_out_q, lo_out_q;
    logic             is_div_q, dbz_q, sign_a_q, sign_b_q, div_by_zero_q;

    logic             accept, op_signed, op_div, zero_div, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] mul_acc, mul_lo, div_acc, div_lo, fix_hi, fix_lo;

    always_comb begin
        op_signed = ~Op[0];
        op_div    = Op[1];
        zero_div  = op_div && (OpB == '0);
        sa        = op_signed & OpA[WIDTH-1];
        sb        = op_signed & OpB[WIDTH-1];
        mag_a     = sa ? -OpA : OpA;
        mag_b     = sb ? -OpB : OpB;
        accept    = (state_q == ST_IDLE) && Start && !Flush;
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .acc_i      (acc_q),
        .lo_i       (lo_q),
        .opnd_i     (opnd_q),
        .is_div_i   (is_div_q),
        .div_zero_i (dbz_q),
        .sign_a_i   (sign_a_q),
        .sign_b_i   (sign_b_q),
        .mul_acc_o  (mul_acc),
        .mul_lo_o   (mul_lo),
        .div_acc_o  (div_acc),
        .div_lo_o   (div_lo),
        .hi_o       (fix_hi),
        .lo_o       (fix_lo)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = zero_div ? ST_FIX : (op_div ? ST_DIV : ST_MUL);
            ST_MUL, ST_DIV: begin
                if (Flush)                     state_d = ST_IDLE;
                else if (cnt_q == CW'(1))      state_d = ST_FIX;
            end
            ST_FIX:  state_d = Flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
        Done    = (state_q == ST_DONE);
        WriteHI = Done;
        WriteLO = Done;
        Stall   = Busy && (Start || ReadHILO);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            lo_q          <= '0;
            opnd_q        <= '0;
            is_div_q      <= 1'b0;
            dbz_q         <= 1'b0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            hi_out_q      <= '0;
            lo_out_q      <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (accept) begin
                    cnt_q         <= CW'(WIDTH);
                    acc_q         <= zero_div ? OpA : '0;
                    lo_q          <= mag_a;
                    opnd_q        <= mag_b;
                    is_div_q      <= op_div;
                    dbz_q         <= zero_div;
                    sign_a_q      <= sa;
                    sign_b_q      <= sb;
                    div_by_zero_q <= 1'b0;
                end
                ST_MUL: begin
                    acc_q <= mul_acc;
                    lo_q  <= mul_lo;
                    cnt_q <= cnt_q - CW'(1);
                end
                ST_DIV: begin
                    acc_q <= div_acc;
                    lo_q  <= div_lo;
                    cnt_q <= cnt_q - CW'(1);
                end
                ST_FIX: if (!Flush) begin
                    hi_out_q <= fix_hi;
                    lo_out_q <= fix_lo;
                    if (dbz_q) div_by_zero_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign HIOut     = hi_out_q;
    assign LOOut     = lo_out_q;
    assign DivByZero = div_by_zero_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. It owns an iterative shift-add multiplier and restoring divider, and writes the 64-bit result into the HI/LO registers. It sits beside the Execute stage. It asserts Stall toward the PC and the pipeline registers while busy, but only if a younger instruction issues another mul/div or reads HI/LO. Non-HI/LO instructions keep flowing during an operation.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH (HI = upper WIDTH, LO = lower WIDTH)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
Start  in  1  Execute holds a valid mul/div op this cycle
Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
OpA  in  WIDTH  rs operand (forwarded value)
OpB  in  WIDTH  rt operand (forwarded value)
ReadHILO  in  1  Decode holds MFHI/MFLO/MTHI/MTLO
Flush  in  1  abort the in-flight operation (exception or redirect)
Busy  out  1  operation in flight
Stall  out  1  hold IF/ID/EX; equals Busy & (Start | ReadHILO)
Done  out  1  single-cycle completion pulse
WriteHI  out  1  HI write enable, equals Done
WriteLO  out  1  LO write enable, equals Done
HIOut  out  WIDTH  HI result; MULT: product[63:32]; DIV: remainder
LOOut  out  WIDTH  LO result; MULT: product[31:0]; DIV: quotient
DivByZero  out  1  sticky flag, set on DIV/DIVU with OpB==0; cleared by next accepted Start

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; Busy, Stall, Done, WriteHI, WriteLO, DivByZero = 0; HIOut, LOOut = 0; iteration counter = 0.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE + Start: latch Op, sign flags and operand magnitudes. Signed ops take the two's-complement absolute value; unsigned ops take the raw value. Counter = WIDTH. Go to MUL or DIV. Exception: DIV/DIVU with OpB==0 goes straight to FIX with the divide-by-zero result.
- MUL: one shift-add step per cycle on a {acc[WIDTH:0], multiplier} register. Counter decrements each cycle; at 1, go to FIX.
- DIV: one restoring step per cycle. Shift {rem, quo} left 1 and trial-subtract the divisor from a WIDTH+1-bit rem. If the result is non-negative, keep it and set quo bit 0. Counter decrements; at 1, go to FIX.
- FIX: apply signs.
  - Signed MULT: negate the 64-bit product if signA^signB.
  - Signed DIV: quotient negated if signA^signB; remainder takes the sign of OpA.
  - Register HIOut/LOOut. Go to DONE.
- DONE: Done/WriteHI/WriteLO high for exactly this cycle; Busy=0 in this cycle. Go to IDLE.
- Latency: Start sampled at edge N → Busy from N+1 through N+WIDTH+1 → Done at cycle N+WIDTH+2 (34 for WIDTH=32). Divide-by-zero: Done at N+2.
- Busy is high in MUL, DIV and FIX only.
- Start while Busy: not accepted. Stall holds the instruction in Execute. Start is re-sampled in IDLE, which first occurs the cycle after DONE. This gives back-to-back ops a 1-cycle gap.
- ReadHILO while Busy: Stall=1 until Busy falls.
  - In the DONE cycle, Stall=0. HI/LO are written at the end of DONE, so the reader sees the new value only through the HILO write-bypass.
  - The HILO register therefore needs write-through bypass; the Forwarding/Hazard block treats Done as a HILO write.
- Divide-by-zero: HIOut=OpA, LOOut={WIDTH{1}}, DivByZero=1.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LOOut=0x80000000, HIOut=0, with no flag. This falls out of the magnitude path with no special case.
- Flush: from any state, the next state is IDLE. No Done or write is produced, and HIOut/LOOut keep their old values.
  - Flush and Start in the same IDLE cycle: Flush wins and Start is dropped.
  - Flush in the DONE cycle: the write still completes.
- Rst asserted mid-operation: immediate return to reset values, with no write.
- Outputs HIOut/LOOut hold their last result until the next FIX.

Decomposition:
- Shared package muldiv_pkg: Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the FSM state encoding, and the WIDTH default.
- One natural sub-module, muldiv_datapath. It holds the combinational step logic: the add/shift step, the restoring subtract/compare, and the FIX negation. The sequencer keeps the FSM, counter, registers and Stall logic.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, Start at cycle 0 → Done at cycle 34; HI=0xFFFFFFFE, LO=0x00000001; Busy high for cycles 1–33.
- MULT -7 × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Also DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → Done at cycle 2; HI=100, LO=0xFFFFFFFF, DivByZero=1. The next Start clears DivByZero.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, DivByZero=0.
- Hazards:
  - ReadHILO asserted at cycle 5 of a MULT → Stall=1 through cycle 33 and 0 at cycle 34.
  - A second Start at cycle 10 → Stall held; second op accepted at cycle 35 with Done at cycle 69.
  - A non-HI/LO instruction during Busy → Stall=0.
- Flush at cycle 12 of a DIV → IDLE at cycle 13, no Done, HI/LO unchanged. Rst low at cycle 20 of a MULT → all outputs 0 immediately.
